// File: rtl/ppi_hs.sv
// ppi_hs: clocked, parametrised 8255-style peripheral interface.
//
// Provides NPORTS independent WIDTH-bit ports. Each port can be programmed at
// run time as basic input, basic output, strobed input (STB/IBF) or strobed
// output (OBF/ACK). Strobed ports have their own interrupt and overrun flags.
//
// Ports:
//   Clk      - system clock, all state changes on the rising edge
//   nReset   - asynchronous active-low reset
//   nCs/nRe/nWr - CPU chip select, read and write strobes (active low)
//   A        - register address: 0..NPORTS-1 = port, NPORTS = control/status
//   DIn      - CPU write data
//   DOut     - registered CPU read data, held until the next read
//   PortIn   - peripheral input data, port p at [p*WIDTH +: WIDTH]
//   PortOut  - peripheral output latches, same packing as PortIn
//   PortOe   - 1 when port p is in an output mode
//   nStb     - strobed-input strobes (active low)
//   nAck     - strobed-output acknowledges (active low)
//   Ibf      - input buffer full
//   nObf     - output buffer full (active low)
//   Intr     - per-port interrupt
//   IntrAny  - OR of Intr
module ppi_hs #(
  parameter int WIDTH  = 8,
  parameter int NPORTS = 3,
  parameter int AW     = 2
) (
  input  logic                     Clk,
  input  logic                     nReset,
  input  logic                     nCs,
  input  logic                     nRe,
  input  logic                     nWr,
  input  logic [AW-1:0]            A,
  input  logic [WIDTH-1:0]         DIn,
  output logic [WIDTH-1:0]         DOut,
  input  logic [NPORTS*WIDTH-1:0]  PortIn,
  output logic [NPORTS*WIDTH-1:0]  PortOut,
  output logic [NPORTS-1:0]        PortOe,
  input  logic [NPORTS-1:0]        nStb,
  input  logic [NPORTS-1:0]        nAck,
  output logic [NPORTS-1:0]        Ibf,
  output logic [NPORTS-1:0]        nObf,
  output logic [NPORTS-1:0]        Intr,
  output logic                     IntrAny
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  localparam logic [1:0] M_BIN  = 2'b00;
  localparam logic [1:0] M_BOUT = 2'b01;
  localparam logic [1:0] M_SIN  = 2'b10;
  localparam logic [1:0] M_SOUT = 2'b11;

  // Per-port state
  logic [NPORTS-1:0][1:0]       mode_q, mode_d;
  logic [NPORTS-1:0]            ie_q, ie_d;
  logic [NPORTS-1:0][WIDTH-1:0] out_q, out_d;
  logic [NPORTS-1:0][WIDTH-1:0] in_q, in_d;
  logic [NPORTS-1:0]            ibf_q, ibf_d;
  logic [NPORTS-1:0]            nobf_q, nobf_d;
  logic [NPORTS-1:0]            intr_q, intr_d;
  logic [NPORTS-1:0]            ovr_q, ovr_d;

  logic [IW-1:0]                sel_q, sel_d;
  logic [WIDTH-1:0]             dout_q, dout_d;

  // Bus strobe edge detection
  logic wr_prev_q, rd_prev_q;
  logic wr_act, rd_act, wr_det, rd_det, is_ctl;

  // Handshake synchronizers. Reset to 0 so a strobe held low across reset
  // release looks "already low" and needs a fresh high-to-low transition.
  logic [NPORTS-1:0] stb_s1_q, stb_s2_q, stb_s3_q;
  logic [NPORTS-1:0] ack_s1_q, ack_s2_q, ack_s3_q;
  logic [NPORTS-1:0] stb_fall, ack_fall;

  logic [IW-1:0] cidx;
  logic          cvalid;
  logic [5:0]    stat6;

  assign wr_act = ~nCs & ~nWr;
  assign rd_act = ~nCs & ~nRe;
  assign wr_det = wr_act & ~wr_prev_q;
  // A write detected together with a read swallows the read.
  assign rd_det = rd_act & ~rd_prev_q & ~wr_det;
  assign is_ctl = (int'(A) == NPORTS);

  assign stb_fall = stb_s3_q & ~stb_s2_q;
  assign ack_fall = ack_s3_q & ~ack_s2_q;

  assign cidx   = DIn[3 +: IW];
  assign cvalid = (int'(cidx) < NPORTS);

  always_comb begin
    mode_d = mode_q;
    ie_d   = ie_q;
    out_d  = out_q;
    in_d   = in_q;
    ibf_d  = ibf_q;
    nobf_d = nobf_q;
    intr_d = intr_q;
    ovr_d  = ovr_q;
    sel_d  = sel_q;
    dout_d = dout_q;
    stat6  = '0;

    for (int p = 0; p < NPORTS; p++) begin
      if (int'(sel_q) == p) begin
        stat6 = {intr_q[p], ovr_q[p],
                 (mode_q[p] == M_SIN) ? ibf_q[p] :
                 (mode_q[p] == M_SOUT) ? ~nobf_q[p] : 1'b0,
                 ie_q[p], mode_q[p]};
      end
    end

    if (rd_det) begin
      dout_d = is_ctl ? WIDTH'(stat6) : '0;
    end

    for (int p = 0; p < NPORTS; p++) begin
      logic wr_p, rd_p;
      wr_p = wr_det & (int'(A) == p);
      rd_p = rd_det & (int'(A) == p);

      if (rd_p) begin
        case (mode_q[p])
          M_BIN:   dout_d = PortIn[p*WIDTH +: WIDTH];
          M_SIN:   dout_d = in_q[p];
          default: dout_d = out_q[p];
        endcase
      end

      // Status read clears overrun; a same-cycle overrun event below re-sets it.
      if (rd_det && is_ctl && (int'(sel_q) == p)) begin
        ovr_d[p] = 1'b0;
      end

      case (mode_q[p])
        M_BOUT: begin
          if (wr_p) out_d[p] = DIn;
        end
        M_SIN: begin
          if (stb_fall[p]) begin
            // A coincident read empties the buffer, so the new strobe is not an overrun.
            if (!ibf_q[p] || rd_p) begin
              in_d[p]  = PortIn[p*WIDTH +: WIDTH];
              ibf_d[p] = 1'b1;
              if (ie_q[p]) intr_d[p] = 1'b1;
            end else begin
              ovr_d[p] = 1'b1;
            end
          end else if (rd_p) begin
            ibf_d[p]  = 1'b0;
            intr_d[p] = 1'b0;
          end
        end
        M_SOUT: begin
          if (wr_p) begin
            out_d[p]  = DIn;
            nobf_d[p] = 1'b0;
            intr_d[p] = 1'b0;
            if (!nobf_q[p]) ovr_d[p] = 1'b1;
          end else if (ack_fall[p] && !nobf_q[p]) begin
            nobf_d[p] = 1'b1;
            if (ie_q[p]) intr_d[p] = 1'b1;
          end
        end
        default: ;
      endcase

      if (wr_det && is_ctl && cvalid && (int'(cidx) == p)) begin
        mode_d[p] = DIn[1:0];
        ie_d[p]   = DIn[2];
        out_d[p]  = '0;
        ibf_d[p]  = 1'b0;
        nobf_d[p] = 1'b1;
        intr_d[p] = 1'b0;
        ovr_d[p]  = 1'b0;
      end
    end

    if (wr_det && is_ctl && cvalid) begin
      sel_d = cidx;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      mode_q    <= '0;
      ie_q      <= '0;
      out_q     <= '0;
      in_q      <= '0;
      ibf_q     <= '0;
      nobf_q    <= '1;
      intr_q    <= '0;
      ovr_q     <= '0;
      sel_q     <= '0;
      dout_q    <= '0;
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      stb_s1_q  <= '0;
      stb_s2_q  <= '0;
      stb_s3_q  <= '0;
      ack_s1_q  <= '0;
      ack_s2_q  <= '0;
      ack_s3_q  <= '0;
    end else begin
      mode_q    <= mode_d;
      ie_q      <= ie_d;
      out_q     <= out_d;
      in_q      <= in_d;
      ibf_q     <= ibf_d;
      nobf_q    <= nobf_d;
      intr_q    <= intr_d;
      ovr_q     <= ovr_d;
      sel_q     <= sel_d;
      dout_q    <= dout_d;
      wr_prev_q <= wr_act;
      rd_prev_q <= rd_act;
      stb_s1_q  <= nStb;
      stb_s2_q  <= stb_s1_q;
      stb_s3_q  <= stb_s2_q;
      ack_s1_q  <= nAck;
      ack_s2_q  <= ack_s1_q;
      ack_s3_q  <= ack_s2_q;
    end
  end

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      PortOe[p] = mode_q[p][0];
    end
  end

  assign PortOut = out_q;
  assign DOut    = dout_q;
  assign Ibf     = ibf_q;
  assign nObf    = nobf_q;
  assign Intr    = intr_q;
  assign IntrAny = |intr_q;

endmodule

// File: tb/tb_ppi_hs.sv
module tb_ppi_hs;

  localparam int WIDTH  = 8;
  localparam int NPORTS = 3;
  localparam int AW     = 2;

  logic                    Clk = 1'b0;
  logic                    nReset;
  logic                    nCs, nRe, nWr;
  logic [AW-1:0]           A;
  logic [WIDTH-1:0]        DIn;
  logic [WIDTH-1:0]        DOut;
  logic [NPORTS*WIDTH-1:0] PortIn;
  logic [NPORTS*WIDTH-1:0] PortOut;
  logic [NPORTS-1:0]       PortOe;
  logic [NPORTS-1:0]       nStb, nAck;
  logic [NPORTS-1:0]       Ibf, nObf, Intr;
  logic                    IntrAny;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] rd;

  ppi_hs #(.WIDTH(WIDTH), .NPORTS(NPORTS), .AW(AW)) dut (
    .Clk(Clk), .nReset(nReset), .nCs(nCs), .nRe(nRe), .nWr(nWr), .A(A),
    .DIn(DIn), .DOut(DOut), .PortIn(PortIn), .PortOut(PortOut),
    .PortOe(PortOe), .nStb(nStb), .nAck(nAck), .Ibf(Ibf), .nObf(nObf),
    .Intr(Intr), .IntrAny(IntrAny)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge Clk);
    A = a; DIn = d; nCs = 1'b0; nWr = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    nCs = 1'b1; nWr = 1'b1;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [WIDTH-1:0] d);
    @(negedge Clk);
    A = a; nCs = 1'b0; nRe = 1'b0;
    @(posedge Clk); #1;
    d = DOut;
    @(negedge Clk);
    nCs = 1'b1; nRe = 1'b1;
  endtask

  task automatic pulse_stb(input int p);
    @(negedge Clk); nStb[p] = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); nStb[p] = 1'b1;
    repeat (2) @(posedge Clk);
  endtask

  task automatic pulse_ack(input int p);
    @(negedge Clk); nAck[p] = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); nAck[p] = 1'b1;
    repeat (2) @(posedge Clk);
  endtask

  initial begin
    nReset = 1'b0; nCs = 1'b1; nRe = 1'b1; nWr = 1'b1;
    A = '0; DIn = '0; PortIn = '0; nStb = '1; nAck = '1;

    // Reset state
    repeat (3) @(posedge Clk); #1;
    chk("rst_oe", PortOe, 3'b000);
    chk("rst_nobf", nObf, 3'b111);
    chk("rst_ibf", Ibf, 3'b000);
    chk("rst_intrany", IntrAny, 1'b0);
    chk("rst_dout", DOut, 8'h00);
    @(negedge Clk); nReset = 1'b1;
    repeat (2) @(posedge Clk);

    // Basic input on port 2
    PortIn[23:16] = 8'h9C;
    bus_read(2'd2, rd);
    chk("bin_read", rd, 8'h9C);

    // Port 1 basic out, long strobe performs a single write
    bus_write(2'd3, 8'h0D);
    chk("bout_oe", PortOe, 3'b010);
    @(negedge Clk);
    A = 2'd1; DIn = 8'hA5; nCs = 1'b0; nWr = 1'b0;
    @(posedge Clk); #1;
    chk("bout_detect", PortOut[15:8], 8'hA5);
    @(negedge Clk); DIn = 8'h5A;
    repeat (4) @(posedge Clk); #1;
    chk("bout_single", PortOut[15:8], 8'hA5);
    @(negedge Clk); nCs = 1'b1; nWr = 1'b1;
    bus_read(2'd1, rd);
    chk("bout_read", rd, 8'hA5);

    // Out-of-range index is ignored
    bus_write(2'd3, 8'h1E);
    chk("ctl_badidx", PortOe, 3'b010);

    // Port 0 strobed input with IE
    bus_write(2'd3, 8'h06);
    PortIn[7:0] = 8'h3C;
    @(negedge Clk); nStb[0] = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    chk("sin_early", Ibf[0], 1'b0);
    @(posedge Clk); #1;
    chk("sin_ibf", Ibf[0], 1'b1);
    chk("sin_intr", Intr[0], 1'b1);
    @(negedge Clk); nStb[0] = 1'b1;
    repeat (3) @(posedge Clk);
    PortIn[7:0] = 8'h77;
    pulse_stb(0);
    bus_read(2'd3, rd);
    chk("sin_stat_ovr", rd, 8'h3E);
    bus_read(2'd3, rd);
    chk("sin_stat_clr", rd, 8'h2E);
    bus_read(2'd0, rd);
    chk("sin_read", rd, 8'h3C);
    chk("sin_ibf_clr", Ibf[0], 1'b0);
    chk("sin_intr_clr", Intr[0], 1'b0);

    // Read coincident with a synchronized strobe edge
    PortIn[7:0] = 8'h11;
    pulse_stb(0);
    chk("coin_pre_ibf", Ibf[0], 1'b1);
    PortIn[7:0] = 8'h22;
    @(negedge Clk); nStb[0] = 1'b0;
    @(posedge Clk); @(posedge Clk);
    @(negedge Clk); A = 2'd0; nCs = 1'b0; nRe = 1'b0;
    @(posedge Clk); #1;
    chk("coin_rd_old", DOut, 8'h11);
    chk("coin_ibf", Ibf[0], 1'b1);
    chk("coin_intr", Intr[0], 1'b1);
    @(negedge Clk); nCs = 1'b1; nRe = 1'b1; nStb[0] = 1'b1;
    repeat (2) @(posedge Clk);
    bus_read(2'd3, rd);
    chk("coin_stat", rd, 8'h2E);
    bus_read(2'd0, rd);
    chk("coin_newdata", rd, 8'h22);

    // Port 2 strobed output with IE
    bus_write(2'd3, 8'h17);
    chk("sout_oe", PortOe, 3'b110);
    bus_write(2'd2, 8'h81);
    chk("sout_nobf", nObf, 3'b011);
    chk("sout_data", PortOut[23:16], 8'h81);
    pulse_ack(2);
    chk("sout_ack_nobf", nObf, 3'b111);
    chk("sout_ack_intr", Intr[2], 1'b1);
    chk("sout_intrany", IntrAny, 1'b1);

    // Write coincident with a synchronized ack edge
    @(negedge Clk); nAck[2] = 1'b0;
    @(posedge Clk); @(posedge Clk);
    @(negedge Clk); A = 2'd2; DIn = 8'h42; nCs = 1'b0; nWr = 1'b0;
    @(posedge Clk); #1;
    chk("coinw_nobf", nObf[2], 1'b0);
    chk("coinw_intr", Intr[2], 1'b0);
    chk("coinw_data", PortOut[23:16], 8'h42);
    @(negedge Clk); nCs = 1'b1; nWr = 1'b1; nAck[2] = 1'b1;
    repeat (2) @(posedge Clk);
    bus_read(2'd3, rd);
    chk("sout_stat", rd, 8'h0F);
    bus_write(2'd2, 8'h43);
    bus_read(2'd3, rd);
    chk("sout_stat_ovr", rd, 8'h1F);
    bus_read(2'd3, rd);
    chk("sout_stat_clr", rd, 8'h0F);
    chk("port1_kept", PortOut[15:8], 8'hA5);

    // Reset mid-handshake with strobe held low through release
    bus_write(2'd3, 8'h06);
    PortIn[7:0] = 8'h55;
    pulse_stb(0);
    chk("mr_pre_ibf", Ibf[0], 1'b1);
    @(negedge Clk); nStb[0] = 1'b0;
    #2 nReset = 1'b0;
    #1;
    chk("mr_ibf", Ibf, 3'b000);
    chk("mr_oe", PortOe, 3'b000);
    chk("mr_out", PortOut, 24'h000000);
    @(negedge Clk); nReset = 1'b1;
    bus_write(2'd3, 8'h06);
    repeat (5) @(posedge Clk); #1;
    chk("mr_held_noibf", Ibf[0], 1'b0);
    @(negedge Clk); nStb[0] = 1'b1;
    repeat (3) @(posedge Clk);
    PortIn[7:0] = 8'h66;
    @(negedge Clk); nStb[0] = 1'b0;
    repeat (3) @(posedge Clk); #1;
    chk("mr_fresh_ibf", Ibf[0], 1'b1);
    @(negedge Clk); nStb[0] = 1'b1;
    bus_read(2'd0, rd);
    chk("mr_fresh_data", rd, 8'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
